// File: rtl/yz_code_decoder.sv
// Receive-side decoder for the {y,z} code stream: decodes to {a,b,c}/amb/err, buffers entries in a FIFO,
// and halts intake after HALT_N consecutive illegal codes. Define DROP_ILLEGAL_EN to keep illegal codes out of the FIFO.
module yz_code_decoder #(
    parameter int DEPTH  = 4,
    parameter int ERR_W  = 8,
    parameter int HALT_N = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic             in_y,
    input  logic             in_z,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2:0]       out_abc,
    output logic             out_amb,
    output logic             out_err,
    output logic             halted,
    input  logic             clr_halt,
    output logic [ERR_W-1:0] err_cnt
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(HALT_N + 1);
    localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_t;

    typedef struct packed {
        logic       err;
        logic       amb;
        logic [2:0] abc;
    } entry_t;

    state_t          state;
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW:0]     count;
    logic [CW-1:0]   consec;
    entry_t          mem [DEPTH];
    entry_t          dec;
    entry_t          head;
    logic            push;
    logic            wr_en;
    logic            pop;

`ifdef DROP_ILLEGAL_EN
    localparam logic ERR_KEEP = 1'b0;
    assign wr_en = push && !dec.err;
`else
    localparam logic ERR_KEEP = 1'b1;
    assign wr_en = push;
`endif

    // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
    always_comb begin
        dec = '0;
        case ({in_y, in_z})
            2'b11:   dec = '{err: 1'b0, amb: 1'b0, abc: 3'b110};
            2'b01:   dec = '{err: 1'b0, amb: 1'b1, abc: 3'b111};
            2'b00:   dec = '{err: 1'b0, amb: 1'b1, abc: 3'b100};
            default: dec = '{err: 1'b1, amb: 1'b0, abc: 3'b000};
        endcase
    end

    assign in_ready  = (state == RUN) && (count < FULL);
    assign push      = in_valid && in_ready;
    assign out_valid = (count != '0);
    assign pop       = out_valid && out_ready;
    assign head      = mem[rd_ptr];
    assign out_abc   = out_valid ? head.abc : 3'b000;
    assign out_amb   = out_valid && head.amb;
    assign out_err   = out_valid && head.err && ERR_KEEP;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + AW'(1);
            if (pop)   rd_ptr <= rd_ptr + AW'(1);
            case ({wr_en, pop})
                2'b10:   count <= count + (AW + 1)'(1);
                2'b01:   count <= count - (AW + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage is not reset; out_valid/count gate every read, so stale contents are never visible.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= dec;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= RUN;
            halted  <= 1'b0;
            consec  <= '0;
            err_cnt <= '0;
        end else begin
            if (push && dec.err && (err_cnt != '1)) err_cnt <= err_cnt + ERR_W'(1);
            case (state)
                RUN: begin
                    if (push) begin
                        if (dec.err) begin
                            consec <= consec + CW'(1);
                            // The accept that completes the run moves to HALT on this same edge.
                            if (consec == CW'(HALT_N - 1)) begin
                                state  <= HALT;
                                halted <= 1'b1;
                            end
                        end else begin
                            consec <= '0;
                        end
                    end
                end
                HALT: begin
                    if (clr_halt) begin
                        state  <= RUN;
                        halted <= 1'b0;
                        consec <= '0;
                    end
                end
                default: begin
                    state  <= RUN;
                    halted <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_yz_code_decoder.sv
// Scoreboard bench for yz_code_decoder: expected entries queued at accept, compared as the FIFO emits them.
module tb_yz_code_decoder;

    localparam int DEPTH  = 4;
    localparam int ERR_W  = 8;
    localparam int HALT_N = 3;
`ifdef DROP_ILLEGAL_EN
    localparam bit DROP = 1'b1;
`else
    localparam bit DROP = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_y;
    logic             in_z;
    logic             in_ready;
    logic             out_valid;
    logic             out_ready;
    logic [2:0]       out_abc;
    logic             out_amb;
    logic             out_err;
    logic             halted;
    logic             clr_halt;
    logic [ERR_W-1:0] err_cnt;

    int               checks = 0;
    int               errors = 0;
    int               pops   = 0;
    logic [4:0]       sb[$];
    int               exp_err;
    int               exp_consec;
    bit               exp_halt;

    yz_code_decoder #(.DEPTH(DEPTH), .ERR_W(ERR_W), .HALT_N(HALT_N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_y      (in_y),
        .in_z      (in_z),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_abc   (out_abc),
        .out_amb   (out_amb),
        .out_err   (out_err),
        .halted    (halted),
        .clr_halt  (clr_halt),
        .err_cnt   (err_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected {err,amb,abc} per code.
    function automatic logic [4:0] model(input logic [1:0] yz);
        case (yz)
            2'b11:   return 5'b00110;
            2'b01:   return 5'b01111;
            2'b00:   return 5'b01100;
            default: return 5'b10000;
        endcase
    endfunction

    // Called just after a falling edge; returns just after the falling edge following the accept.
    task automatic push_code(input logic [1:0] yz, output int waits);
        in_valid = 1'b1;
        in_y     = yz[1];
        in_z     = yz[0];
        waits    = 0;
        while (!in_ready && waits < 100) begin
            @(negedge clk);
            waits++;
        end
        if (!in_ready) begin
            check("push_timeout", in_ready, 1);
        end else begin
            if (!(DROP && yz == 2'b10)) sb.push_back(model(yz));
            if (yz == 2'b10) begin
                if (exp_err < 255) exp_err++;
                exp_consec++;
                if (exp_consec == HALT_N) exp_halt = 1'b1;
            end else begin
                exp_consec = 0;
            end
            @(posedge clk);
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        out_ready = 1'b1;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        #2;
        check("drain_sb_empty", sb.size(), 0);
        check("drain_out_valid", out_valid, 0);
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        #1;
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_out", out_valid, 0);
            end else begin
                check("fifo_out", {out_err, out_amb, out_abc}, sb.pop_front());
                pops++;
            end
        end
    end

    initial begin
        int w;
        int p0;
        logic [1:0] codes4 [6] = '{2'b10, 2'b10, 2'b11, 2'b10, 2'b10, 2'b10};
        logic [1:0] codes6 [3] = '{2'b11, 2'b10, 2'b00};

        rst_n = 1'b0; in_valid = 1'b0; in_y = 1'b0; in_z = 1'b0;
        out_ready = 1'b0; clr_halt = 1'b0;
        exp_err = 0; exp_consec = 0; exp_halt = 1'b0;
        #12;
        check("rst_out_valid", out_valid, 0);
        check("rst_halted", halted, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_err_cnt", err_cnt, 0);
        check("rst_out_data", {out_err, out_amb, out_abc}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic decode, one-cycle latency.
        out_ready = 1'b1;
        push_code(2'b11, w); check("lat_11", out_valid, 1);
        push_code(2'b01, w); check("lat_01", out_valid, 1);
        push_code(2'b00, w); check("lat_00", out_valid, 1);
        drain();

        // Fill to DEPTH, hold the fifth, release one slot.
        out_ready = 1'b0;
        push_code(2'b11, w); push_code(2'b01, w); push_code(2'b00, w); push_code(2'b11, w);
        check("full_in_ready", in_ready, 0);
        in_valid = 1'b1; in_y = 1'b0; in_z = 1'b1;
        @(negedge clk);
        check("full_held", in_ready, 0);
        check("full_out_valid", out_valid, 1);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        push_code(2'b01, w);
        check("fifth_wait", w, 0);
        check("refull_in_ready", in_ready, 0);
        drain();

        // Two entries resident, push and pop together for 10 cycles.
        out_ready = 1'b0;
        push_code(2'b00, w); push_code(2'b11, w);
        p0 = pops;
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            push_code((i % 3 == 0) ? 2'b11 : (i % 3 == 1) ? 2'b01 : 2'b00, w);
            check("ovl_wait", w, 0);
        end
        out_ready = 1'b0;
        check("ovl_pops", pops - p0, 10);
        check("ovl_sb_size", sb.size(), 2);
        drain();
        check("ovl_total", pops - p0, 12);

        // Illegal run -> HALT, drain, clear.
        out_ready = 1'b1;
        foreach (codes4[i]) begin
            push_code(codes4[i], w);
            check("ill_err_cnt", err_cnt, exp_err);
            check("ill_halted", halted, exp_halt);
        end
        check("halt_in_ready", in_ready, 0);
        in_valid = 1'b1; in_y = 1'b1; in_z = 1'b1;
        repeat (3) @(negedge clk);
        check("halt_blocked", in_ready, 0);
        in_valid = 1'b0;
        drain();
        check("halt_drained_halted", halted, 1);
        clr_halt = 1'b1;
        @(negedge clk);
        clr_halt = 1'b0;
        exp_halt = 1'b0; exp_consec = 0;
        check("clr_halted", halted, 0);
        check("clr_in_ready", in_ready, 1);
        check("clr_err_cnt", err_cnt, 5);
        push_code(2'b10, w); push_code(2'b10, w);
        check("clr_consec", halted, 0);
        check("clr_err_cnt2", err_cnt, exp_err);
        push_code(2'b11, w);
        drain();

        // Asynchronous reset with entries queued and HALT active.
        out_ready = 1'b0;
        push_code(2'b10, w); push_code(2'b10, w); push_code(2'b10, w);
        check("pre_rst_halted", halted, 1);
        check("pre_rst_out_valid", out_valid, !DROP);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_out_valid", out_valid, 0);
        check("async_halted", halted, 0);
        check("async_err_cnt", err_cnt, 0);
        check("async_in_ready", in_ready, 1);
        sb.delete();
        exp_err = 0; exp_consec = 0; exp_halt = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Mixed legal/illegal stream; illegal entry queued or dropped by build.
        p0 = pops;
        out_ready = 1'b1;
        foreach (codes6[i]) push_code(codes6[i], w);
        drain();
        check("mix_pops", pops - p0, DROP ? 2 : 3);
        check("mix_err_cnt", err_cnt, 1);
        check("mix_halted", halted, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got %0d expected 0", 1);
        $fatal(1, "timeout");
    end

endmodule
